// File: rtl/demux_rr_param.sv
// demux_rr_param: distributes a word stream round-robin over NUM_CH channels and presents each full frame with valid/ready.
// Ports:
//   clk8f       - sole clock, rising edge
//   reset       - synchronous, active-low
//   data_in     - input word (DATA_W)
//   valid_in    - data_in is valid this cycle
//   in_ready    - a word can be accepted this cycle (combinational from out_ready)
//   data_out    - frame data, channel k at [k*DATA_W +: DATA_W]
//   valid_out   - per-channel valid of the presented frame
//   frame_valid - a frame is presented on data_out
//   out_ready   - consumer accepts the presented frame
//   ch_ptr      - next channel slot to be filled
// Optional: define DEMUX_FLUSH_EN to flush a partial frame after FLUSH_CYC idle cycles.
module demux_rr_param #(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 4,
  parameter int PTR_W     = $clog2(NUM_CH),
  parameter int FLUSH_CYC = 16
) (
  input  logic                     clk8f,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out,
  output logic                     frame_valid,
  input  logic                     out_ready,
  output logic [PTR_W-1:0]         ch_ptr
);
  if (NUM_CH < 2 || NUM_CH > 16 || FLUSH_CYC < 1) begin : g_bad_param
    $error("demux_rr_param: illegal parameter values");
  end
  logic [DATA_W-1:0] slots [NUM_CH-1];
  logic [NUM_CH*DATA_W-1:0] full_data;
  logic last, acc;
  assign last     = ch_ptr == PTR_W'(NUM_CH - 1);
  // Only the last slot stalls: it needs the output register to be free or freeing.
  assign in_ready = reset && (!last || !frame_valid || out_ready);
  assign acc      = valid_in && in_ready;
  for (genvar k = 0; k < NUM_CH - 1; k++) begin : g_full
    assign full_data[k*DATA_W +: DATA_W] = slots[k];
  end
  // The final word bypasses the collect buffer straight into the output register.
  assign full_data[(NUM_CH-1)*DATA_W +: DATA_W] = data_in;
`ifdef DEMUX_FLUSH_EN
  localparam int CNT_W = $clog2(FLUSH_CYC + 1);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [CNT_W-1:0] idle_cnt;
  logic [NUM_CH*DATA_W-1:0] part_data;
  logic [NUM_CH-1:0] part_valid;
  logic flush;
  for (genvar k = 0; k < NUM_CH - 1; k++) begin : g_part
    assign part_valid[k] = ch_ptr > PTR_W'(k);
    assign part_data[k*DATA_W +: DATA_W] = part_valid[k] ? slots[k] : '0;
  end
  assign part_valid[NUM_CH-1] = 1'b0;
  assign part_data[(NUM_CH-1)*DATA_W +: DATA_W] = '0;
  // An accept on the same edge wins over the flush.
  assign flush = state == FILL && !acc && idle_cnt == CNT_W'(FLUSH_CYC) && (!frame_valid || out_ready);
`endif
  always_ff @(posedge clk8f) begin
    if (!reset) begin
      ch_ptr      <= '0;
      data_out    <= '0;
      valid_out   <= '0;
      frame_valid <= 1'b0;
      for (int i = 0; i < NUM_CH - 1; i++) slots[i] <= '0;
`ifdef DEMUX_FLUSH_EN
      state    <= IDLE;
      idle_cnt <= '0;
`endif
    end else begin
      if (acc) ch_ptr <= last ? '0 : ch_ptr + PTR_W'(1);
      for (int i = 0; i < NUM_CH - 1; i++) if (acc && ch_ptr == PTR_W'(i)) slots[i] <= data_in;
      if (acc && last) begin
        data_out    <= full_data;
        valid_out   <= '1;
        frame_valid <= 1'b1;
      end
`ifdef DEMUX_FLUSH_EN
      else if (flush) begin
        data_out    <= part_data;
        valid_out   <= part_valid;
        frame_valid <= 1'b1;
        ch_ptr      <= '0;
      end
`endif
      else if (frame_valid && out_ready) begin
        frame_valid <= 1'b0;
        valid_out   <= '0;
      end
`ifdef DEMUX_FLUSH_EN
      state    <= ((acc && last) || flush) ? IDLE : acc ? FILL : state;
      idle_cnt <= (acc || flush || state == IDLE) ? '0 :
                  idle_cnt == CNT_W'(FLUSH_CYC) ? idle_cnt : idle_cnt + CNT_W'(1);
`endif
    end
  end
endmodule

// File: doc/demux_rr_param.md
Name: demux_rr_param

Overview:
- Parametrised successor to the two-output 8-bit demux.
- Takes one word stream at the clk8f rate and distributes words round-robin over NUM_CH channels.
- Presents each completed frame (one word per channel) in parallel, with a valid/ready handshake on the output side.
- Runs in a single clock domain and generates no divided clocks. Sits between the serial front end and the per-lane consumers.

Parameters:
- DATA_W, 8, width of each data word.
- NUM_CH, 4, number of output channels; legal range 2..16.
- PTR_W, $clog2(NUM_CH), derived width of the channel pointer; do not override.
- FLUSH_CYC, 16, idle cycles before a partial-frame flush; used only with DEMUX_FLUSH_EN.

Ports:
- clk8f, in, 1, sole clock; all logic on the rising edge.
- reset, in, 1, synchronous, active-low.
- data_in, in, DATA_W, input word.
- valid_in, in, 1, data_in is valid this cycle.
- in_ready, out, 1, block can accept a word this cycle.
- data_out, out, NUM_CH*DATA_W, frame data; channel k occupies [k*DATA_W +: DATA_W].
- valid_out, out, NUM_CH, per-channel valid for the presented frame.
- frame_valid, out, 1, a frame is presented on data_out.
- out_ready, in, 1, consumer accepts the presented frame.
- ch_ptr, out, PTR_W, next channel slot to be filled.

Behaviour:
- Reset (reset==0 at an edge):
  - ch_ptr, collect buffer, data_out, valid_out and frame_valid all go to 0; state goes to IDLE.
  - in_ready is 0 while reset is low.
  - A partial frame in progress is discarded.
- Accept rule: a word is accepted when valid_in && in_ready at the edge. It is written to slot ch_ptr, then ch_ptr increments and wraps from NUM_CH-1 to 0.
- Collect buffer: holds slots 0..NUM_CH-2 only. The last word is not buffered; it goes straight into the output register.
- Frame completion:
  - Occurs when the word accepted has ch_ptr==NUM_CH-1.
  - At that same edge, the output register loads slots 0..NUM_CH-2 plus data_in.
  - valid_out becomes all ones and frame_valid becomes 1.
  - Latency: frame_valid is high in the cycle after the last word's accept edge.
- in_ready = reset && (ch_ptr != NUM_CH-1 || !frame_valid || out_ready). This is combinational from out_ready; no bubble when the consumer is ready.
- Output handshake:
  - The frame is consumed at an edge with frame_valid && out_ready.
  - If a new frame completes on that same edge, the output reloads and frame_valid stays 1.
  - Otherwise frame_valid and valid_out go to 0. data_out holds its last value.
  - data_out and valid_out are stable while frame_valid && !out_ready.
- States:
  - IDLE (ch_ptr==0, no partial data): goes to FILL on accept.
  - FILL (ch_ptr!=0): goes to IDLE on frame completion or flush.
  - The output-side state is frame_valid alone.
- Invalid input cycles (valid_in==0) do not advance ch_ptr; channel assignment counts accepted words only.
- Backpressure: input stalls only on the last slot. Slots 0..NUM_CH-2 keep filling even while the output is blocked.

Optional Feature:
- Macro: DEMUX_FLUSH_EN.
- When defined:
  - In FILL, an idle counter counts consecutive cycles with no accept and clears on every accept.
  - When the counter reaches FLUSH_CYC and the output register is free (!frame_valid || out_ready), the block emits a partial frame.
  - Partial frame: slots 0..ch_ptr-1 with their valid_out bits set; all other channels' data and valid bits are 0.
  - ch_ptr goes to 0 and the state goes to IDLE.
  - An accept on the flush edge takes priority: the word is accepted and no flush occurs.
- When not defined: a partial frame waits indefinitely, and valid_out is only ever all-zeros or all-ones.

Test Plan:
- Reset low for 3 cycles, then high → in_ready=1, ch_ptr=0, frame_valid=0, valid_out=4'b0000.
- Send 8'hA0, A1, A2, A3 back-to-back with out_ready=1 → one cycle later data_out=32'hA3A2A1A0, valid_out=4'hF, frame_valid=1.
- 12 words with valid_in toggling every cycle → three frames, in order, no slot skipped; ch_ptr advances only on valid cycles.
- out_ready=0 with a frame held, then 4 more words → in_ready drops at ch_ptr=3; raising out_ready produces the second frame the next cycle; no word lost.
- Reset asserted after 2 words → ch_ptr=0; the next 4 words form a clean frame.
- With DEMUX_FLUSH_EN: send 2 words (B0, B1), then idle for 16 cycles → partial frame data_out=32'h0000B1B0, valid_out=4'b0011.
